// File: rtl/counter.sv
// counter: WIDTH-bit unsigned loadable free-running up-counter.
// Per-edge priority is reset, then parallel load, then increment.
// Reset is synchronous and active-high. dout comes straight from the
// count register, so no input has a combinational path to the output.
module counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: a load replaces the count; otherwise add one and wrap
   // modulo 2^WIDTH with no flag.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = data;
      end else begin
         count_d = count_q + WIDTH'(1);
      end
   end

   // Count register. Reset wins over load and increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign dout = count_q;

endmodule

// File: tb/tb_counter.sv
// tb_counter: randomized and directed scoreboard bench for counter.
// A reference model computes the expected count at every rising edge
// from the sampled inputs and queues it. A monitor pops each entry just
// after the edge and compares it with dout.
module tb_counter;

   localparam int WIDTH = 4;
   localparam int MODV  = 1 << WIDTH;

   logic             clk = 1'b0;
   logic             rst;
   logic             load;
   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] dout;

   int    checks   = 0;
   int    failures = 0;
   int    exp_q[$];
   string tag_q[$];
   int    model_cnt   = 0;
   bit    model_known = 1'b0;
   string cur_tag     = "init";

   counter #(.WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .data (data),
      .dout (dout)
   );

   always #5 clk = ~clk;

   // Reference model: follows the counter rules with plain arithmetic.
   always @(posedge clk) begin
      if (rst === 1'b1) begin
         model_cnt   = 0;
         model_known = 1'b1;
      end else if (model_known) begin
         if (load === 1'b1) model_cnt = int'(data);
         else               model_cnt = (model_cnt + 1) % MODV;
      end
      if (model_known) begin
         exp_q.push_back(model_cnt);
         tag_q.push_back(cur_tag);
      end
   end

   // Monitor: compares dout with the queued expectation after each edge.
   always @(posedge clk) begin
      int    e;
      string t;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         checks++;
         if (dout !== WIDTH'(e)) begin
            failures++;
            $display("FAIL %s: dout=%0d expected=%0d", t, dout, e);
         end
      end
   end

   // Apply one set of inputs for the next rising edge.
   task automatic step(input logic r, input logic l, input logic [WIDTH-1:0] d,
                       input string tg);
      @(negedge clk);
      rst     = r;
      load    = l;
      data    = d;
      cur_tag = tg;
   endtask

   // Toggle all inputs between edges. dout must keep its value, then the
   // final values are settled before the next rising edge.
   task automatic glitch(input logic r, input logic l, input logic [WIDTH-1:0] d,
                         input string tg);
      logic [WIDTH-1:0] hold;
      @(negedge clk);
      hold = WIDTH'(model_cnt);
      rst  = 1'b1;
      load = 1'b1;
      data = ~d;
      #2;
      checks++;
      if (dout !== hold) begin
         failures++;
         $display("FAIL midcycle_%s: dout=%0d expected=%0d", tg, dout, hold);
      end
      rst     = r;
      load    = l;
      data    = d;
      cur_tag = tg;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wait_cycles;
      rst  = 1'b0;
      load = 1'b0;
      data = '0;

      // Reset then count
      step(1'b1, 1'b0, 4'd0, "reset");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, "count_after_reset");
      // Load 4 then count
      step(1'b1, 1'b0, 4'd0, "reset2");
      step(1'b0, 1'b1, 4'd4, "load4");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, "count_after_load4");
      // Wrap from 14
      step(1'b0, 1'b1, 4'd14, "load14");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, "wrap");
      // Reset and load on the same edge
      step(1'b1, 1'b1, 4'd9, "rst_and_load");
      step(1'b0, 1'b0, 4'd0, "after_rst_and_load");
      // Held load
      step(1'b0, 1'b1, 4'd3,  "held_load3");
      step(1'b0, 1'b1, 4'd8,  "held_load8");
      step(1'b0, 1'b1, 4'd12, "held_load12");
      // Mid-count reset
      step(1'b0, 1'b1, 4'd5, "load5");
      step(1'b0, 1'b0, 4'd0, "count6");
      step(1'b1, 1'b0, 4'd0, "midcount_reset");
      step(1'b0, 1'b0, 4'd0, "resume1");
      step(1'b0, 1'b0, 4'd0, "resume2");
      // Reset held high keeps zero
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'd7, "rst_held");
      step(1'b0, 1'b0, 4'd0, "first_after_rst");
      // Load all-ones then wrap
      step(1'b0, 1'b1, 4'd15, "load15");
      step(1'b0, 1'b0, 4'd0, "wrap_after_load15");
      // Inputs toggled between edges
      for (int i = 0; i < 4; i++) glitch(1'b0, 1'b0, 4'd0, "glitch_count");
      glitch(1'b0, 1'b1, 4'd10, "glitch_load");

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic r;
         logic l;
         logic [WIDTH-1:0] d;
         r = ($urandom_range(0, 19) == 0);
         l = ($urandom_range(0, 3) == 0);
         d = WIDTH'($urandom);
         if ($urandom_range(0, 9) == 0) glitch(r, l, d, "rand_glitch");
         else                           step(r, l, d, "rand");
      end

      step(1'b0, 1'b0, 4'd0, "drain");
      wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 10) begin
         @(negedge clk);
         wait_cycles++;
      end
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: pending=%0d expected=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
